regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Writer end of the register-file write channel (write_en/write_addr/write_data).
//   Merges two result sources onto the single write port: the in-order pipeline
//   writeback, which never stalls, and a long-latency unit (MDU/divider) using a
//   valid/ready handshake. MDU results are buffered in a small FIFO.
//   Exposes a pending-write query so decode can stall on MDU destinations.
// PARAMETERS
//   FIFO_DEPTH  4   MDU result queue depth; power of two, >= 2
//   CNT_W       $clog2(FIFO_DEPTH+1)  width of fifo_count (derived, localparam)
// PORTS
//   clk           in   1   clock
//   rst           in   1   synchronous, active-high reset
//   pipe_wb_en    in   1   pipeline writeback valid (must be accepted, no stall)
//   pipe_wb_addr  in   5   pipeline destination register (`REG_ADDR_BUS)
//   pipe_wb_data  in   32  pipeline result (`DATA_BUS)
//   mdu_valid     in   1   MDU result valid
//   mdu_ready     out  1   queue can accept an MDU result
//   mdu_addr      in   5   MDU destination register
//   mdu_data      in   32  MDU result
//   flush         in   1   discard all queued MDU results
//   query_addr    in   5   decode source register to check
//   query_hit     out  1   a queued MDU write targets query_addr
//   fifo_count    out  CNT_W  number of queued MDU results
//   write_en      out  1   to register file write channel
//   write_addr    out  5   to register file write channel
//   write_data    out  32  to register file write channel
// BEHAVIOUR
//   - One clock; reset synchronous, active-high. While rst: write_en=0,
//     write_addr=0, write_data=0, FIFO empty (fifo_count=0), mdu_ready=0, query_hit=0.
//   - write_* are registered. Pipeline write at cycle n appears on write_* at n+1.
//   - Per-cycle selection for the output register:
//     1) pipe_wb_en && pipe_wb_addr!=0  -> issue pipeline write; FIFO not popped.
//     2) else FIFO non-empty            -> pop head, issue it.
//     3) else                           -> write_en=0 (addr/data hold last value).
//     A pipe write to addr 0 is dropped and frees the slot for a FIFO pop.
//   - mdu_ready = !rst && fifo_count<FIFO_DEPTH (combinational from count).
//     No pass-through when full: a pop in the same cycle does not raise ready.
//   - Push on mdu_valid && mdu_ready. A result with mdu_addr==0 is handshaken
//     and discarded (not queued).
//   - No bypass: a pushed entry is poppable the following cycle, so an MDU result
//     handshaken at n reaches write_* at n+2 at the earliest.
//   - Simultaneous push and pop: count unchanged, pointers both advance.
//   - FIFO order is preserved. A pipe write and a queued entry to the same
//     register: pipe write issues first, so the queued value lands last.
//     Ordering hazards are decode's job, using query_hit.
//   - query_hit: combinational. 1 iff query_addr!=0 and any valid FIFO entry has
//     an equal address. The output register is excluded because the register file
//     forwards its write channel.
//   - flush: FIFO empty on the next cycle. A handshake in the flush cycle is
//     dropped. A pop in the flush cycle still issues, since write_* are already
//     registered. A pipeline write in the flush cycle still issues.
//   - Reset mid-operation: queued entries are lost and no write issues after rst.
//   - Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
// STRUCTURE
//   - Shared header bus.v: `DATA_BUS, `REG_ADDR_BUS (existing); add `WB_FIFO_DEPTH
//     as the default for FIFO_DEPTH.
//   - Sub-module wb_fifo: synchronous FIFO of {addr,data} with count, and a
//     per-entry address-match vector that is OR-reduced into query_hit.
//   - Top level holds the priority select and the output register.
// TESTING
//   1 Reset: rst=1 for 2 cycles, mdu_valid=1 -> mdu_ready=0, write_en=0,
//     fifo_count=0. After rst drops, write_en stays 0.
//   2 Pipe only: pipe addr 5, data 32'hDEADBEEF at n -> write_en=1, addr 5,
//     data DEADBEEF at n+1. Pipe addr 0 -> write_en=0 next cycle.
//   3 MDU idle path: handshake addr 3, data 32'h12345678 at n with pipe idle
//     -> query_hit(query_addr=3)=1 at n+1 only; write at n+2; fifo_count 1 then 0.
//   4 Contention: pipe writes regs 1..6 every cycle while MDU offers 5 results
//     (regs 10..14) -> mdu_ready drops after 4 accepts. Pipe writes issue
//     back-to-back. Then FIFO drains 10,11,12,13 one per cycle and the 5th is
//     accepted as space frees.
//   5 Full + pop: FIFO full, pipe idle, mdu_valid=1 -> mdu_ready=0 that cycle.
//     fifo_count 4->3 and ready=1 the next cycle.
//   6 Flush: 3 queued (regs 7,8,9), pipe busy, flush=1 -> fifo_count=0 next
//     cycle. No writes to 7/8/9 ever issue; query_hit(7)=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared bus widths, FIFO depth default and entry types for the writeback arbiter
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef WB_FIFO_DEPTH
`define WB_FIFO_DEPTH 4
`endif

package regfile_wb_arbiter_pkg;

    localparam int DATA_W        = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int WB_FIFO_DEPTH = `WB_FIFO_DEPTH;

    // Source chosen for the output register in a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PIPE = 2'd1,
        SEL_FIFO = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// rtl/regfile_wb_arbiter_wb_fifo.sv - MDU result queue with per-entry destination match
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_i         empty the queue at the next edge (push in the same cycle is ignored)
//   push_i          enqueue push_entry_i (caller guarantees not full)
//   push_entry_i    {addr,data} to enqueue
//   pop_i           dequeue head (ignored when empty)
//   head_o          current head entry
//   count_o         number of queued entries
//   query_addr_i    register to look up
//   match_o         per-entry hit: entry valid and its addr equals a non-zero query_addr_i
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  wb_entry_t             push_entry_i,
    input  logic                  pop_i,
    output wb_entry_t             head_o,
    output logic [CNT_W-1:0]      count_o,
    input  logic [REG_ADDR_W-1:0] query_addr_i,
    output logic [DEPTH-1:0]      match_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Set and clear can hit different slots in the same cycle, so merge them here.
    always_comb begin
        valid_d = valid_q;
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(do_pop);
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by valid_q.
    always_ff @(posedge clk) begin
        if (push_i && !rst && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_o[i] = valid_q[i] && (query_addr_i != '0) && (mem_q[i].addr == query_addr_i);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges pipeline writeback and queued MDU results onto the register-file write port
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   pipe_wb_en/addr/data         pipeline writeback, always accepted, highest priority
//   mdu_valid/ready/addr/data    MDU result handshake into the queue
//   flush                        discard all queued MDU results
//   query_addr, query_hit        decode lookup: is a queued MDU write pending for this register
//   fifo_count                   number of queued MDU results
//   write_en/addr/data           registered register-file write channel
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int FIFO_DEPTH = WB_FIFO_DEPTH,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_wb_en,
    input  logic [REG_ADDR_W-1:0] pipe_wb_addr,
    input  logic [DATA_W-1:0]     pipe_wb_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0]     mdu_data,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] query_addr,
    output logic                  query_hit,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  write_en,
    output logic [REG_ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0]     write_data
);

    wb_sel_e               sel;
    wb_entry_t             head, push_entry;
    logic [CNT_W-1:0]      count;
    logic [FIFO_DEPTH-1:0] match;
    logic                  push, pop;

    logic                  write_en_q, write_en_d;
    logic [REG_ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0]     write_data_q, write_data_d;

    // Ready comes from the registered count only: a pop this cycle does not open a slot.
    assign mdu_ready = !rst && (count < CNT_W'(FIFO_DEPTH));

    // Results for r0 complete the handshake but are never queued.
    assign push            = mdu_valid && mdu_ready && (mdu_addr != '0) && !flush;
    assign push_entry.addr = mdu_addr;
    assign push_entry.data = mdu_data;

    // A pipe write to r0 is a no-op and gives the slot to the queue.
    always_comb begin
        sel = SEL_NONE;
        if (pipe_wb_en && (pipe_wb_addr != '0)) begin
            sel = SEL_PIPE;
        end else if (count != '0) begin
            sel = SEL_FIFO;
        end
    end

    assign pop = (sel == SEL_FIFO);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count),
        .query_addr_i (query_addr),
        .match_o      (match)
    );

    // The output register is not searched: the register file forwards its own write port.
    assign query_hit  = !rst && (|match);
    assign fifo_count = rst ? '0 : count;

    // Address/data hold when idle so the write channel only toggles on real writes.
    always_comb begin
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        case (sel)
            SEL_PIPE: begin
                write_en_d   = 1'b1;
                write_addr_d = pipe_wb_addr;
                write_data_d = pipe_wb_data;
            end
            SEL_FIFO: begin
                write_en_d   = 1'b1;
                write_addr_d = head.addr;
                write_data_d = head.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed table-driven bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        flush;
    logic [4:0]  query_addr;
    logic        query_hit;
    logic [2:0]  fifo_count;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_wb_addr (pipe_wb_addr),
        .pipe_wb_data (pipe_wb_data),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_addr     (mdu_addr),
        .mdu_data     (mdu_data),
        .flush        (flush),
        .query_addr   (query_addr),
        .query_hit    (query_hit),
        .fifo_count   (fifo_count),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .write_data   (write_data)
    );

    typedef struct {
        logic        pen;
        logic [4:0]  paddr;
        logic [31:0] pdata;
        logic        mval;
        logic [4:0]  maddr;
        logic [31:0] mdata;
        logic [4:0]  qaddr;
        // before the edge
        logic        e_ready;
        logic        e_hit;
        logic [2:0]  e_cnt;
        // after the edge
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pen, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic fl, input logic [4:0] qa);
        pipe_wb_en   = pen;
        pipe_wb_addr = pa;
        pipe_wb_data = pd;
        mdu_valid    = mv;
        mdu_addr     = ma;
        mdu_data     = md;
        flush        = fl;
        query_addr   = qa;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic pen, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] qa, input logic er, input logic eh, input logic [2:0] ec,
                       input logic ew, input logic [4:0] ewa, input logic [31:0] ewd);
        vec_t v;
        v.pen = pen; v.paddr = pa; v.pdata = pd;
        v.mval = mv; v.maddr = ma; v.mdata = md; v.qaddr = qa;
        v.e_ready = er; v.e_hit = eh; v.e_cnt = ec;
        v.e_wen = ew; v.e_waddr = ewa; v.e_wdata = ewd;
        vecs.push_back(v);
    endtask

    initial begin
        // Cycle-by-cycle table, starting right after reset with an empty queue.
        //   pen pa  pdata          mv ma  mdata          qa  rdy hit cnt  wen wa  wdata
        add(1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0,  1, 0, 0,  1, 5,  32'hDEADBEEF);
        add(1, 0,  32'h11111111, 0, 0,  32'h0,        0,  1, 0, 0,  0, 5,  32'hDEADBEEF);
        add(0, 0,  32'h0,        1, 3,  32'h12345678, 3,  1, 0, 0,  0, 5,  32'hDEADBEEF);
        add(0, 0,  32'h0,        0, 0,  32'h0,        3,  1, 1, 1,  1, 3,  32'h12345678);
        add(0, 0,  32'h0,        0, 0,  32'h0,        3,  1, 0, 0,  0, 3,  32'h12345678);
        // contention: pipe r1..r6 back-to-back, MDU offers r10..r14
        add(1, 1,  32'h101,      1, 10, 32'hA0A,      0,  1, 0, 0,  1, 1,  32'h101);
        add(1, 2,  32'h102,      1, 11, 32'hA0B,      10, 1, 1, 1,  1, 2,  32'h102);
        add(1, 3,  32'h103,      1, 12, 32'hA0C,      0,  1, 0, 2,  1, 3,  32'h103);
        add(1, 4,  32'h104,      1, 13, 32'hA0D,      0,  1, 0, 3,  1, 4,  32'h104);
        add(1, 5,  32'h105,      1, 14, 32'hA0E,      12, 0, 1, 4,  1, 5,  32'h105);
        add(1, 6,  32'h106,      1, 14, 32'hA0E,      14, 0, 0, 4,  1, 6,  32'h106);
        // full, pipe idle: pop without raising ready
        add(0, 0,  32'h0,        1, 14, 32'hA0E,      0,  0, 0, 4,  1, 10, 32'hA0A);
        add(0, 0,  32'h0,        1, 14, 32'hA0E,      0,  1, 0, 3,  1, 11, 32'hA0B);
        add(0, 0,  32'h0,        0, 0,  32'h0,        14, 1, 1, 3,  1, 12, 32'hA0C);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0,  1, 0, 2,  1, 13, 32'hA0D);
        add(0, 0,  32'h0,        0, 0,  32'h0,        14, 1, 1, 1,  1, 14, 32'hA0E);
        add(0, 0,  32'h0,        0, 0,  32'h0,        14, 1, 0, 0,  0, 14, 32'hA0E);
        // MDU result for r0 is handshaken and dropped
        add(0, 0,  32'h0,        1, 0,  32'h55,       0,  1, 0, 0,  0, 14, 32'hA0E);
        add(0, 0,  32'h0,        0, 0,  32'h0,        0,  1, 0, 0,  0, 14, 32'hA0E);

        // Reset: held 2 cycles with an MDU result offered.
        rst = 1'b1;
        drive(0, 0, 0, 1, 4, 32'h44, 0, 4);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("rst%0d_ready", i), 32'(mdu_ready), 32'd0);
            tick();
            chk($sformatf("rst%0d_wen", i), 32'(write_en), 32'd0);
            chk($sformatf("rst%0d_cnt", i), 32'(fifo_count), 32'd0);
        end
        chk("rst_waddr", 32'(write_addr), 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post_rst_wen", 32'(write_en), 32'd0);
        chk("post_rst_cnt", 32'(fifo_count), 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].pen, vecs[i].paddr, vecs[i].pdata,
                  vecs[i].mval, vecs[i].maddr, vecs[i].mdata, 1'b0, vecs[i].qaddr);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(mdu_ready),  32'(vecs[i].e_ready));
            chk($sformatf("v%0d_hit", i),   32'(query_hit),  32'(vecs[i].e_hit));
            chk($sformatf("v%0d_cnt", i),   32'(fifo_count), 32'(vecs[i].e_cnt));
            tick();
            chk($sformatf("v%0d_wen", i),   32'(write_en),   32'(vecs[i].e_wen));
            chk($sformatf("v%0d_waddr", i), 32'(write_addr), 32'(vecs[i].e_waddr));
            chk($sformatf("v%0d_wdata", i), write_data,      vecs[i].e_wdata);
        end

        // Flush: queue r7,r8,r9 behind a busy pipe, then flush with pipe still busy.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(20 + i), 32'(32'h200 + i), 1, 5'(7 + i), 32'(32'h700 + i), 0, 0);
            tick();
        end
        drive(1, 23, 32'h223, 1, 15, 32'h715, 1, 7);
        #1;
        chk("fl_cnt_before", 32'(fifo_count), 32'd3);
        chk("fl_hit_before", 32'(query_hit), 32'd1);
        tick();
        chk("fl_pipe_wen", 32'(write_en), 32'd1);
        chk("fl_pipe_waddr", 32'(write_addr), 32'd23);
        drive(0, 0, 0, 0, 0, 0, 0, 7);
        #1;
        chk("fl_cnt_after", 32'(fifo_count), 32'd0);
        chk("fl_hit_after", 32'(query_hit), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fl_idle%0d_wen", i), 32'(write_en), 32'd0);
        end

        // Pop in the flush cycle still issues.
        drive(1, 24, 32'h224, 1, 16, 32'h716, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("flpop_wen", 32'(write_en), 32'd1);
        chk("flpop_waddr", 32'(write_addr), 32'd16);
        chk("flpop_wdata", write_data, 32'h716);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("flpop_cnt", 32'(fifo_count), 32'd0);

        // Reset mid-operation: queued entries vanish, nothing issues afterwards.
        for (int i = 0; i < 2; i++) begin
            drive(1, 5'(25 + i), 32'h0, 1, 5'(17 + i), 32'(32'h800 + i), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 17);
        rst = 1'b1;
        #1;
        chk("mrst_ready", 32'(mdu_ready), 32'd0);
        chk("mrst_hit", 32'(query_hit), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mrst%0d_cnt", i), 32'(fifo_count), 32'd0);
            tick();
            chk($sformatf("mrst%0d_wen", i), 32'(write_en), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Writes to flushed registers must never appear.
    always @(negedge clk) begin
        if (rst === 1'b0 && write_en === 1'b1 && write_addr inside {5'd7, 5'd8, 5'd9}) begin
            checks++;
            failures++;
            $display("FAIL flushed_write: got addr %0d want none", write_addr);
        end
    end

endmodule
